// File: rtl/gps_pkg.sv
// gps_pkg: shared constants, types and helpers for the GPS code generator.
//   - C/A and P sequence lengths, SV range limit and default PY keystream word
//   - FSM state type and the C/A phase-select tap pair type
//   - P-code LFSR tap masks and initial states; bit k-1 is stage k and the
//     output stage (stage 12) is bit 11
//   - ca_taps(): PRN -> G2 phase-select pair lookup
//   - lfsr12_step(): one shift of a 12-stage Fibonacci LFSR
package gps_pkg;

   localparam int CA_LEN = 13;
   localparam int P_LEN  = 128;
   localparam int MAX_SV = 37;

   localparam logic [127:0] PY_KEY_DEFAULT = 128'h3C4FCF098815F7ABA6D2AE2816157E2B;

   // Feedback masks: a set bit k-1 means term x^k is in the polynomial.
   localparam logic [11:0] X1A_TAPS = 12'hCA0;  // x^6, x^8, x^11, x^12
   localparam logic [11:0] X1B_TAPS = 12'hF93;  // x, x^2, x^5, x^8..x^12
   localparam logic [11:0] X2A_TAPS = 12'hFDD;  // x, x^3..x^5, x^7..x^12
   localparam logic [11:0] X2B_TAPS = 12'h98E;  // x^2..x^4, x^8, x^9, x^12

   localparam logic [11:0] X1A_INIT = 12'b001001001000;
   localparam logic [11:0] X1B_INIT = 12'b010101010100;
   localparam logic [11:0] X2A_INIT = 12'b100100100101;
   localparam logic [11:0] X2B_INIT = 12'b010101010100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
   } ca_taps_t;

   // G2 phase-select pair for each PRN; out-of-range PRNs map to PRN 1.
   function automatic ca_taps_t ca_taps(input logic [5:0] prn);
      ca_taps_t t;
      case (prn)
         6'd1:    t = {4'd2, 4'd6};
         6'd2:    t = {4'd3, 4'd7};
         6'd3:    t = {4'd4, 4'd8};
         6'd4:    t = {4'd5, 4'd9};
         6'd5:    t = {4'd1, 4'd9};
         6'd6:    t = {4'd2, 4'd10};
         6'd7:    t = {4'd1, 4'd8};
         6'd8:    t = {4'd2, 4'd9};
         6'd9:    t = {4'd3, 4'd10};
         6'd10:   t = {4'd2, 4'd3};
         6'd11:   t = {4'd3, 4'd4};
         6'd12:   t = {4'd5, 4'd6};
         6'd13:   t = {4'd6, 4'd7};
         6'd14:   t = {4'd7, 4'd8};
         6'd15:   t = {4'd8, 4'd9};
         6'd16:   t = {4'd9, 4'd10};
         6'd17:   t = {4'd1, 4'd4};
         6'd18:   t = {4'd2, 4'd5};
         6'd19:   t = {4'd3, 4'd6};
         6'd20:   t = {4'd4, 4'd7};
         6'd21:   t = {4'd5, 4'd8};
         6'd22:   t = {4'd6, 4'd9};
         6'd23:   t = {4'd1, 4'd3};
         6'd24:   t = {4'd4, 4'd6};
         6'd25:   t = {4'd5, 4'd7};
         6'd26:   t = {4'd6, 4'd8};
         6'd27:   t = {4'd7, 4'd9};
         6'd28:   t = {4'd8, 4'd10};
         6'd29:   t = {4'd1, 4'd6};
         6'd30:   t = {4'd2, 4'd7};
         6'd31:   t = {4'd3, 4'd8};
         6'd32:   t = {4'd4, 4'd9};
         6'd33:   t = {4'd5, 4'd10};
         6'd34:   t = {4'd4, 4'd10};
         6'd35:   t = {4'd1, 4'd7};
         6'd36:   t = {4'd2, 4'd8};
         6'd37:   t = {4'd4, 4'd10};
         default: t = {4'd2, 4'd6};
      endcase
      return t;
   endfunction

   function automatic logic [11:0] lfsr12_step(input logic [11:0] r, input logic [11:0] taps);
      return {r[10:0], ^(r & taps)};
   endfunction

endpackage

// File: rtl/gps_ca_gen.sv
// gps_ca_gen: C/A Gold-code chip generator (G1 = 1+x^3+x^10,
// G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10), stages numbered 1..10.
//   clk, rst_n    : clock, asynchronous active-low reset
//   init          : reload both registers with all ones
//   en            : advance both registers by one chip
//   tap_a, tap_b  : G2 phase-select stages (1..10)
//   chip          : current chip, G1[10] ^ G2[a] ^ G2[b]; consumed on en
module gps_ca_gen
   import gps_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       init,
   input  logic       en,
   input  logic [3:0] tap_a,
   input  logic [3:0] tap_b,
   output logic       chip
);

   logic [10:1] g1;
   logic [10:1] g2;

   assign chip = g1[10] ^ g2[tap_a] ^ g2[tap_b];

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, as real flops do.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g1 <= '1;
         g2 <= '1;
      end else if (init) begin
         g1 <= '1;
         g2 <= '1;
      end else if (en) begin
         g1 <= {g1[9:1], g1[3] ^ g1[10]};
         g2 <= {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
      end
   end

endmodule

// File: rtl/gps_code_gen.sv
// gps_code_gen: one round of GPS ranging code per rising edge of start.
//   clk, rst_n     : clock, asynchronous active-low reset
//   sv_num         : SV/PRN select 1..37 (others act as 1), sampled at start
//   start          : rising edge begins a round when idle
//   ca_code        : first 13 C/A chips, first chip in bit 12
//   p_code         : 128 P chips, first chip in bit 127
//   py_code        : p_code ^ KEY, registered when the round completes
//   py_code_valid  : high while py_code holds a completed round
// Timeline: E0 detects start, chips shift on E1..E128, py_code at E129.
module gps_code_gen
   import gps_pkg::*;
#(
   parameter logic [127:0] KEY = PY_KEY_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [5:0]   sv_num,
   input  logic         start,
   output logic [12:0]  ca_code,
   output logic [127:0] p_code,
   output logic [127:0] py_code,
   output logic         py_code_valid
);

   state_t      state, state_nxt;
   logic        start_d;
   logic [7:0]  chip_cnt;
   logic [5:0]  sv_sel;
   logic [5:0]  dly_idx;
   ca_taps_t    taps;
   logic        round_start;
   logic        ca_step;
   logic        ca_chip;
   logic        x1, x2;
   logic [11:0] x1a, x1b, x2a, x2b;
   logic [36:0] x2_hist;  // bit 0 = most recent X2 chip

   assign round_start = (state == ST_IDLE) && start && !start_d;
   assign ca_step     = (state == ST_RUN) && (chip_cnt < 8'(CA_LEN));
   assign taps        = ca_taps(sv_sel);
   assign x1          = x1a[11] ^ x1b[11];
   assign x2          = x2a[11] ^ x2b[11];
   // X2 delayed by sv_sel chips sits sv_sel-1 places down the history.
   assign dly_idx     = sv_sel - 6'd1;

   gps_ca_gen u_ca_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .init  (round_start),
      .en    (ca_step),
      .tap_a (taps.a),
      .tap_b (taps.b),
      .chip  (ca_chip)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (round_start) state_nxt = ST_RUN;
         ST_RUN:  if (chip_cnt == 8'(P_LEN - 1)) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: x2_hist is a plain shift register, so it is reset with everything
   // else; it must read as zero until filled anyway.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_d       <= 1'b0;
         chip_cnt      <= '0;
         sv_sel        <= 6'd1;
         x1a           <= X1A_INIT;
         x1b           <= X1B_INIT;
         x2a           <= X2A_INIT;
         x2b           <= X2B_INIT;
         x2_hist       <= '0;
         ca_code       <= '0;
         p_code        <= '0;
         py_code       <= '0;
         py_code_valid <= 1'b0;
      end else begin
         start_d <= start;
         if (round_start) begin
            sv_sel        <= (sv_num == 6'd0 || sv_num > 6'(MAX_SV)) ? 6'd1 : sv_num;
            chip_cnt      <= '0;
            x1a           <= X1A_INIT;
            x1b           <= X1B_INIT;
            x2a           <= X2A_INIT;
            x2b           <= X2B_INIT;
            x2_hist       <= '0;
            ca_code       <= '0;
            p_code        <= '0;
            py_code_valid <= 1'b0;
         end else if (state == ST_RUN) begin
            chip_cnt <= chip_cnt + 8'd1;
            x1a      <= lfsr12_step(x1a, X1A_TAPS);
            x1b      <= lfsr12_step(x1b, X1B_TAPS);
            x2a      <= lfsr12_step(x2a, X2A_TAPS);
            x2b      <= lfsr12_step(x2b, X2B_TAPS);
            x2_hist  <= {x2_hist[35:0], x2};
            p_code   <= {p_code[126:0], x1 ^ x2_hist[dly_idx]};
            if (ca_step) ca_code <= {ca_code[11:0], ca_chip};
         end else if (state == ST_DONE) begin
            py_code       <= p_code ^ KEY;
            py_code_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gps_code_gen.sv
// tb_gps_code_gen: directed self-checking bench for gps_code_gen.
// Expected C/A and P sequences come from bench-side reference models written
// stage-by-stage from the generator polynomials.
module tb_gps_code_gen;

   localparam logic [127:0] KEY = 128'h3C4FCF098815F7ABA6D2AE2816157E2B;

   logic         clk;
   logic         rst_n;
   logic [5:0]   sv_num;
   logic         start;
   logic [12:0]  ca_code;
   logic [127:0] p_code;
   logic [127:0] py_code;
   logic         py_code_valid;

   int compared   = 0;
   int mismatched = 0;

   gps_code_gen dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sv_num        (sv_num),
      .start         (start),
      .ca_code       (ca_code),
      .p_code        (p_code),
      .py_code       (py_code),
      .py_code_valid (py_code_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // C/A reference: G1/G2 with stages 1..10, chip taken before each shift.
   function automatic logic [12:0] ca_model(input int a, input int b);
      logic [10:1] g1 = '1;
      logic [10:1] g2 = '1;
      logic [12:0] r  = '0;
      for (int i = 0; i < 13; i++) begin
         r  = {r[11:0], g1[10] ^ g2[a] ^ g2[b]};
         g1 = {g1[9:1], g1[3] ^ g1[10]};
         g2 = {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
      end
      return r;
   endfunction

   // P reference: four 12-stage LFSRs, output stage 12, X2 delayed n chips.
   function automatic logic [127:0] p_model(input int n);
      logic [12:1]  a1 = 12'b001001001000;
      logic [12:1]  b1 = 12'b010101010100;
      logic [12:1]  a2 = 12'b100100100101;
      logic [12:1]  b2 = 12'b010101010100;
      logic         x2h [1:128];
      logic         d;
      logic [127:0] p = '0;
      for (int j = 1; j <= 128; j++) begin
         x2h[j] = a2[12] ^ b2[12];
         d      = (j > n) ? x2h[j-n] : 1'b0;
         p      = {p[126:0], a1[12] ^ b1[12] ^ d};
         a1 = {a1[11:1], a1[6] ^ a1[8] ^ a1[11] ^ a1[12]};
         b1 = {b1[11:1], b1[1] ^ b1[2] ^ b1[5] ^ b1[8] ^ b1[9] ^ b1[10] ^ b1[11] ^ b1[12]};
         a2 = {a2[11:1], a2[1] ^ a2[3] ^ a2[4] ^ a2[5] ^ a2[7] ^ a2[8] ^ a2[9] ^ a2[10]
                         ^ a2[11] ^ a2[12]};
         b2 = {b2[11:1], b2[2] ^ b2[3] ^ b2[4] ^ b2[8] ^ b2[9] ^ b2[12]};
      end
      return p;
   endfunction

   // One round from idle: start pulse, latency count, full result checks.
   // disturb: change sv_num and pulse start mid-round (both must be ignored).
   task automatic run_round(input string tag, input logic [5:0] sv, input int a, input int b,
                            input int n, input logic [9:0] top_exp, input bit disturb,
                            output logic [12:0] ca_o, output logic [127:0] p_o,
                            output logic [127:0] py_o);
      int          lat;
      logic [12:0] ca13;
      logic [127:0] p_exp;
      p_exp  = p_model(n);
      sv_num = sv;
      start  = 1'b1;
      tick();                    // E0
      start  = 1'b0;
      check({tag, " valid_drop"}, 128'(py_code_valid), 128'(1'b0));
      lat  = 0;
      ca13 = '0;
      while (lat < 300 && py_code_valid !== 1'b1) begin
         tick();
         lat++;
         if (lat == 13) ca13 = ca_code;
         if (disturb && lat == 5)  sv_num = 6'd20;
         if (disturb && lat == 40) start = 1'b1;
         if (disturb && lat == 42) start = 1'b0;
      end
      check({tag, " latency"}, 128'(lat), 128'(129));
      check({tag, " ca_top10"}, 128'(ca13[12:3]), 128'(top_exp));
      check({tag, " ca_frozen"}, 128'(ca_code), 128'(ca13));
      check({tag, " ca_code"}, 128'(ca_code), 128'(ca_model(a, b)));
      check({tag, " p_code"}, p_code, p_exp);
      check({tag, " py_code"}, py_code, p_exp ^ KEY);
      ca_o = ca_code;
      p_o  = p_code;
      py_o = py_code;
   endtask

   initial begin
      logic [12:0]  ca_a, ca_b, ca_c, m5, m37;
      logic [127:0] p_a, p_b, p_c, py_a, py_b, py_c, p_hold;
      int           lat, low_cnt;

      // Reset held for 32 cycles.
      rst_n  = 1'b0;
      start  = 1'b0;
      sv_num = 6'd0;
      repeat (32) tick();
      check("rst ca_code", 128'(ca_code), 128'(0));
      check("rst p_code", p_code, 128'(0));
      check("rst py_code", py_code, 128'(0));
      check("rst valid", 128'(py_code_valid), 128'(0));
      rst_n = 1'b1;
      repeat (3) tick();
      check("idle no start", 128'(py_code_valid), 128'(0));

      // PRN 1.
      run_round("sv1", 6'd1, 2, 6, 1, 10'b1100100000, 1'b0, ca_a, p_a, py_a);
      check("sv1 valid_hold", 128'(py_code_valid), 128'(1));

      // PRN 12 with start already high when reset releases.
      rst_n  = 1'b0;
      sv_num = 6'd12;
      start  = 1'b1;
      #2;
      check("mid rst valid", 128'(py_code_valid), 128'(0));
      repeat (4) tick();
      rst_n = 1'b1;
      tick();                    // E0
      lat = 0;
      while (lat < 300 && py_code_valid !== 1'b1) begin
         tick();
         lat++;
      end
      check("sv12 latency", 128'(lat), 128'(129));
      check("sv12 ca_top10", 128'(ca_code[12:3]), 128'(10'b1111101000));
      check("sv12 ca_code", 128'(ca_code), 128'(ca_model(5, 6)));
      check("sv12 p_code", p_code, p_model(12));
      check("sv12 py_code", py_code, p_model(12) ^ KEY);
      p_hold  = p_code;
      low_cnt = 0;
      repeat (200) begin
         tick();
         if (py_code_valid !== 1'b1) low_cnt++;
      end
      check("sv12 no_second_round", 128'(low_cnt), 128'(0));
      check("sv12 p_hold", p_code, p_hold);
      start = 1'b0;
      tick();

      // Reset at cycle 60 of a round, then restart with PRN 5.
      sv_num = 6'd12;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      repeat (60) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("abort ca_code", 128'(ca_code), 128'(0));
      check("abort p_code", p_code, 128'(0));
      check("abort py_code", py_code, 128'(0));
      check("abort valid", 128'(py_code_valid), 128'(0));
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      m5 = ca_model(1, 9);
      run_round("sv5", 6'd5, 1, 9, 5, m5[12:3], 1'b0, ca_c, p_c, py_c);

      // sv_num 0 then 1 back to back (second round disturbed mid-flight).
      run_round("sv0", 6'd0, 2, 6, 1, 10'b1100100000, 1'b0, ca_b, p_b, py_b);
      run_round("sv1b", 6'd1, 2, 6, 1, 10'b1100100000, 1'b1, ca_c, p_c, py_c);
      check("0vs1 ca_code", 128'(ca_b), 128'(ca_c));
      check("0vs1 p_code", p_b, p_c);
      check("0vs1 py_code", py_b, py_c);

      // Upper boundary PRN 37 (full 37-chip delay), then out-of-range 63.
      m37 = ca_model(4, 10);
      run_round("sv37", 6'd37, 4, 10, 37, m37[12:3], 1'b0, ca_c, p_c, py_c);
      run_round("sv63", 6'd63, 2, 6, 1, 10'b1100100000, 1'b0, ca_c, p_c, py_c);
      check("63vs1 py_code", py_c, py_a);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
